// File: rtl/scv_pkg.sv
// Shared constants and helpers for the SCV audio output path.
package scv_pkg;
   localparam int SCV_AUD_DECIM  = 125;
   localparam int SCV_AUD_OFFSET = 32000;
   localparam int SCV_AUD_PCM_W  = 9;
   localparam int SCV_AUD_SMP_W  = 16;
   localparam int SCV_AUD_WIDE_W = 18;

   localparam logic signed [SCV_AUD_WIDE_W-1:0] SCV_AUD_SAT_MAX = 18'sd32767;
   localparam logic signed [SCV_AUD_WIDE_W-1:0] SCV_AUD_SAT_MIN = -18'sd32768;

   function automatic logic signed [SCV_AUD_SMP_W-1:0] scv_sat16(
      input logic signed [SCV_AUD_WIDE_W-1:0] v);
      if (v > SCV_AUD_SAT_MAX)
         return 16'sh7fff;
      else if (v < SCV_AUD_SAT_MIN)
         return 16'sh8000;
      else
         return v[SCV_AUD_SMP_W-1:0];
   endfunction
endpackage

// File: rtl/scv_audio_out_if.sv
// Output sample stream with valid/ready handshake and drop counter.
interface scv_audio_out_if;
   import scv_pkg::*;

   logic                             VALID;
   logic                             READY;
   logic signed [SCV_AUD_SMP_W-1:0]  SAMPLE;
   logic [7:0]                       DROP;

   modport master (output VALID, output SAMPLE, output DROP, input READY);
   modport slave  (input VALID, input SAMPLE, input DROP, output READY);
endinterface

// File: rtl/scv_dcblock.sv
// Stage-2 DC-blocking filter: y = x - xp + yp - yp/256, saturated to 16 bits.
module scv_dcblock
   import scv_pkg::*;
(
   input  logic                            CLK,
   input  logic                            RES,
   input  logic                            X_VLD,
   input  logic                            DCB_EN,
   input  logic signed [SCV_AUD_SMP_W-1:0] X,
   output logic                            Y_VLD,
   output logic signed [SCV_AUD_SMP_W-1:0] Y
);
   logic signed [SCV_AUD_SMP_W-1:0]  xp;
   logic signed [SCV_AUD_SMP_W-1:0]  yp;
   logic signed [SCV_AUD_SMP_W-1:0]  yp_sh;
   logic signed [SCV_AUD_WIDE_W-1:0] y_filt;
   logic signed [SCV_AUD_SMP_W-1:0]  y_next;

   always_comb begin
      yp_sh  = yp >>> 8;
      y_filt = {{2{X[15]}}, X} - {{2{xp[15]}}, xp}
             + {{2{yp[15]}}, yp} - {{2{yp_sh[15]}}, yp_sh};
      y_next = DCB_EN ? scv_sat16(y_filt) : X;
   end

   // History tracks every sample so toggling DCB_EN never sees stale state.
   always_ff @(posedge CLK) begin
      if (RES) begin
         xp    <= '0;
         yp    <= '0;
         Y     <= '0;
         Y_VLD <= 1'b0;
      end else begin
         Y_VLD <= X_VLD;
         if (X_VLD) begin
            xp <= X;
            yp <= y_next;
            Y  <= y_next;
         end
      end
   end
endmodule

// File: rtl/scv_audio_out.sv
// Boxcar decimator from PCM_CE rate to 48 kHz, DC blocker, and output handshake.
module scv_audio_out
   import scv_pkg::*;
#(
   parameter int DECIM  = SCV_AUD_DECIM,
   parameter int OFFSET = SCV_AUD_OFFSET
) (
   input  logic                     CLK,
   input  logic                     RES,
   input  logic                     PCM_CE,
   input  logic [SCV_AUD_PCM_W-1:0] PCM,
   input  logic                     DCB_EN,
   scv_audio_out_if.master          aud
);
   localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam logic [CNT_W-1:0]         CNT_LAST = CNT_W'(DECIM - 1);
   localparam logic [SCV_AUD_SMP_W-1:0] OFFSET_U = SCV_AUD_SMP_W'(OFFSET);

   logic [SCV_AUD_SMP_W-1:0]        acc;
   logic [CNT_W-1:0]                cnt;
   logic [SCV_AUD_SMP_W-1:0]        win_sum;
   logic signed [SCV_AUD_SMP_W-1:0] s1_x;
   logic                            s1_vld;
   logic                            s1_dcb;
   logic                            s2_vld;
   logic signed [SCV_AUD_SMP_W-1:0] s2_y;

   always_comb begin
      win_sum = acc + {{(SCV_AUD_SMP_W-SCV_AUD_PCM_W){1'b0}}, PCM};
   end

   always_ff @(posedge CLK) begin
      if (RES) begin
         acc    <= '0;
         cnt    <= '0;
         s1_x   <= '0;
         s1_vld <= 1'b0;
         s1_dcb <= 1'b0;
      end else begin
         s1_vld <= 1'b0;
         if (PCM_CE) begin
            if (cnt == CNT_LAST) begin
               s1_x   <= $signed(win_sum - OFFSET_U);
               s1_dcb <= DCB_EN;
               s1_vld <= 1'b1;
               acc    <= '0;
               cnt    <= '0;
            end else begin
               acc <= win_sum;
               cnt <= cnt + CNT_W'(1);
            end
         end
      end
   end

   scv_dcblock u_dcblock (
      .CLK    (CLK),
      .RES    (RES),
      .X_VLD  (s1_vld),
      .DCB_EN (s1_dcb),
      .X      (s1_x),
      .Y_VLD  (s2_vld),
      .Y      (s2_y)
   );

   // A new sample may replace the held one only on the edge that consumes it.
   always_ff @(posedge CLK) begin
      if (RES) begin
         aud.VALID  <= 1'b0;
         aud.SAMPLE <= '0;
         aud.DROP   <= '0;
      end else if (s2_vld) begin
         if (!aud.VALID || aud.READY) begin
            aud.SAMPLE <= s2_y;
            aud.VALID  <= 1'b1;
         end else if (aud.DROP != 8'hff) begin
            aud.DROP <= aud.DROP + 8'd1;
         end
      end else if (aud.VALID && aud.READY) begin
         aud.VALID <= 1'b0;
      end
   end
endmodule

// File: tb/tb_scv_audio_out.sv
// Directed bench for scv_audio_out: decimation, latency, DC blocker, backpressure, reset.
module tb_scv_audio_out;
   import scv_pkg::*;

   logic       CLK = 1'b0;
   logic       RES;
   logic       PCM_CE;
   logic [8:0] PCM;
   logic       DCB_EN;
   int         n_checks = 0;
   int         n_errors = 0;
   int         nv;

   scv_audio_out_if aud();

   scv_audio_out dut (
      .CLK    (CLK),
      .RES    (RES),
      .PCM_CE (PCM_CE),
      .PCM    (PCM),
      .DCB_EN (DCB_EN),
      .aud    (aud)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Issues n strobes of value v with gap idle cycles between them; returns at
   // the falling edge right after the window-closing rising edge.
   task automatic feed(input int n, input logic [8:0] v, input int gap,
                       output int nvalid);
      nvalid = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge CLK);
         if (aud.VALID) nvalid++;
         PCM_CE = 1'b1;
         PCM    = v;
         if (i < n - 1) begin
            for (int g = 0; g < gap; g++) begin
               @(negedge CLK);
               if (aud.VALID) nvalid++;
               PCM_CE = 1'b0;
               PCM    = 9'h1aa;
            end
         end
      end
      @(negedge CLK);
      if (aud.VALID) nvalid++;
      PCM_CE = 1'b0;
   endtask

   task automatic expect_out(input string tag, input int exp_sample);
      check({tag, "_vld_e0"}, aud.VALID, 0);
      @(negedge CLK);
      check({tag, "_vld_e1"}, aud.VALID, 0);
      @(negedge CLK);
      check({tag, "_vld_e2"}, aud.VALID, 1);
      check({tag, "_sample"}, $signed(aud.SAMPLE), exp_sample);
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RES    = 1'b1;
      PCM_CE = 1'b0;
      repeat (2) @(negedge CLK);
      RES = 1'b0;
   endtask

   initial begin
      RES       = 1'b1;
      PCM_CE    = 1'b0;
      PCM       = 9'd0;
      DCB_EN    = 1'b0;
      aud.READY = 1'b1;
      repeat (3) @(negedge CLK);
      check("rst_valid", aud.VALID, 0);
      check("rst_sample", $signed(aud.SAMPLE), 0);
      check("rst_drop", {24'd0, aud.DROP}, 0);
      RES = 1'b0;

      // Mid-scale input with idle gaps between strobes, then contiguous windows.
      feed(125, 9'd256, 2, nv);
      expect_out("mid_gap", 0);
      feed(250, 9'd256, 0, nv);
      check("mid_valid_count", nv, 1);
      expect_out("mid_w3", 0);
      check("mid_drop", {24'd0, aud.DROP}, 0);

      // Full-scale extremes without the filter.
      feed(125, 9'd511, 0, nv);
      expect_out("max", 31875);
      feed(125, 9'd0, 0, nv);
      expect_out("min", -32000);

      // DC blocker from reset with constant full-scale input.
      do_reset();
      DCB_EN = 1'b1;
      feed(125, 9'd511, 0, nv);
      expect_out("dcb_1", 31875);
      feed(125, 9'd511, 0, nv);
      expect_out("dcb_2", 31751);
      feed(125, 9'd511, 0, nv);
      expect_out("dcb_3", 31627);
      DCB_EN = 1'b0;

      // Backpressure: the first sample is held, later ones counted as dropped.
      do_reset();
      aud.READY = 1'b0;
      feed(125, 9'd511, 0, nv);
      expect_out("bp_first", 31875);
      check("bp_drop0", {24'd0, aud.DROP}, 0);
      feed(125, 9'd0, 0, nv);
      repeat (2) @(negedge CLK);
      check("bp_drop1", {24'd0, aud.DROP}, 1);
      check("bp_hold1", $signed(aud.SAMPLE), 31875);
      feed(298 * 125, 9'd0, 0, nv);
      repeat (2) @(negedge CLK);
      check("bp_drop_sat", {24'd0, aud.DROP}, 255);
      check("bp_hold_end", $signed(aud.SAMPLE), 31875);
      check("bp_valid_held", aud.VALID, 1);
      aud.READY = 1'b1;
      @(negedge CLK);
      aud.READY = 1'b0;
      check("bp_consumed", aud.VALID, 0);
      aud.READY = 1'b1;
      @(negedge CLK);
      check("ready_idle", aud.VALID, 0);
      check("drop_kept", {24'd0, aud.DROP}, 255);

      // Reset mid-window discards the partial sum.
      do_reset();
      check("drop_cleared", {24'd0, aud.DROP}, 0);
      feed(60, 9'd511, 0, nv);
      do_reset();
      feed(125, 9'd256, 0, nv);
      check("rstmid_nostale", nv, 0);
      expect_out("rstmid", 0);

      // Reset while a sample sits in stage 1 cancels it.
      feed(125, 9'd511, 0, nv);
      RES = 1'b1;
      repeat (2) @(negedge CLK);
      RES = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         check("rst_cancel", aud.VALID, 0);
      end

      // Window close on the same edge that consumes the held sample.
      aud.READY = 1'b0;
      feed(125, 9'd511, 0, nv);
      expect_out("coin_held", 31875);
      feed(125, 9'd0, 0, nv);
      @(negedge CLK);
      aud.READY = 1'b1;
      @(negedge CLK);
      aud.READY = 1'b0;
      check("coin_valid", aud.VALID, 1);
      check("coin_sample", $signed(aud.SAMPLE), -32000);
      check("coin_drop", {24'd0, aud.DROP}, 0);
      @(negedge CLK);
      check("coin_valid_hold", aud.VALID, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
